// File: rtl/xpb_lut_bank_pkg.sv
// Shared constants and types for the XPB residue lookup bank.
// LATENCY follows the XPB_LUT_SUM_EN build option.
package xpb_pkg;

  localparam int DATA_W   = 1024;
  localparam int SEL_W    = 5;
  localparam int CHANNELS = 4;

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SUM_W = DATA_W + $clog2(CHANNELS);

`ifdef XPB_LUT_SUM_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 2;
`endif

  typedef logic [DATA_W-1:0] residue_t;

endpackage

// File: rtl/xpb_lut_bank_if.sv
// Load, clear and lookup signals of the XPB residue bank.
// The master drives requests; the slave (the bank) returns status and results.
interface xpb_lut_if
  import xpb_pkg::*;
#(
  parameter int DATA_W   = xpb_pkg::DATA_W,
  parameter int SEL_W    = xpb_pkg::SEL_W,
  parameter int CHANNELS = xpb_pkg::CHANNELS
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SUM_W = DATA_W + $clog2(CHANNELS);

  logic                         tbl_clear;
  logic                         wr_valid;
  logic                         wr_ready;
  logic [CH_W-1:0]              wr_chan;
  logic [SEL_W-1:0]             wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic                         tbl_loaded;
  logic                         lk_valid;
  logic                         lk_ready;
  logic [CHANNELS*SEL_W-1:0]    lk_sel;
  logic                         out_valid;
  logic [CHANNELS*DATA_W-1:0]   out_data;
  logic [SUM_W-1:0]             out_sum;
  logic                         lk_err;

  modport master (
    output tbl_clear, wr_valid, wr_chan, wr_addr, wr_data, lk_valid, lk_sel,
    input  wr_ready, tbl_loaded, lk_ready, out_valid, out_data, out_sum, lk_err
  );

  modport slave (
    input  tbl_clear, wr_valid, wr_chan, wr_addr, wr_data, lk_valid, lk_sel,
    output wr_ready, tbl_loaded, lk_ready, out_valid, out_data, out_sum, lk_err
  );

endinterface

// File: rtl/xpb_lut_bank_chan.sv
// One channel of the residue bank: write decode, storage and registered read.
// Entry 0 is never stored; reading it always yields zero.
module xpb_lut_chan
  import xpb_pkg::*;
#(
  parameter int DATA_W  = xpb_pkg::DATA_W,
  parameter int SEL_W   = xpb_pkg::SEL_W,
  parameter int CH_W    = xpb_pkg::CH_W,
  parameter int CHAN_ID = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_chan,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int DEPTH = 1 << SEL_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              hit;

  assign hit = wr_en && (wr_chan == CH_W'(CHAN_ID)) && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (hit) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (rd_addr == '0) ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/xpb_lut_bank.sv
// Multi-channel runtime-loadable XPB residue tables with a pipelined parallel lookup.
// Define XPB_LUT_SUM_EN to add an adder stage producing out_sum (latency 3 instead of 2).
module xpb_lut_bank
  import xpb_pkg::*;
#(
  parameter int DATA_W   = xpb_pkg::DATA_W,
  parameter int SEL_W    = xpb_pkg::SEL_W,
  parameter int CHANNELS = xpb_pkg::CHANNELS
) (
  input  logic     clk,
  input  logic     rst_n,
  xpb_lut_if.slave bus
);
  localparam int DEPTH = 1 << SEL_W;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                               lk_acc;
  logic                               wr_acc;
  logic                               loaded_q;
  logic                               lk_err_q;
  logic [CHANNELS-1:0][DEPTH-1:1]     bitmap;
  logic [CHANNELS-1:0][DEPTH-1:1]     bitmap_nxt;
  logic                               all_set;
  logic                               s1_valid;
  logic [CHANNELS*DATA_W-1:0]         s1_data;
  logic                               out_valid_q;
  logic [CHANNELS*DATA_W-1:0]         out_data_q;

  // An accepted lookup and a clear both take the cycle away from the load port.
  assign lk_acc       = bus.lk_valid && loaded_q;
  assign bus.wr_ready = !lk_acc && !bus.tbl_clear;
  assign wr_acc       = bus.wr_valid && bus.wr_ready;

  assign bus.lk_ready   = loaded_q;
  assign bus.tbl_loaded = loaded_q;
  assign bus.lk_err     = lk_err_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

  always_comb begin
    bitmap_nxt = bitmap;
    if (bus.tbl_clear) begin
      bitmap_nxt = '0;
    end else if (wr_acc && (bus.wr_addr != '0)) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.wr_chan == CH_W'(c)) bitmap_nxt[c][bus.wr_addr] = 1'b1;
      end
    end
  end

  always_comb begin
    all_set = 1'b1;
    for (int c = 0; c < CHANNELS; c++) all_set = all_set & (&bitmap_nxt[c]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap   <= '0;
      loaded_q <= 1'b0;
      lk_err_q <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      bitmap   <= bitmap_nxt;
      loaded_q <= all_set;
      lk_err_q <= bus.lk_valid && !loaded_q;
      s1_valid <= lk_acc;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    xpb_lut_chan #(
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W),
      .CH_W   (CH_W),
      .CHAN_ID(c)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_acc),
      .wr_chan(bus.wr_chan),
      .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data),
      .rd_en  (lk_acc),
      .rd_addr(bus.lk_sel[c*SEL_W +: SEL_W]),
      .rd_data(s1_data[c*DATA_W +: DATA_W])
    );
  end

`ifdef XPB_LUT_SUM_EN
  localparam int SUM_W = DATA_W + $clog2(CHANNELS);

  logic                       s2_valid;
  logic [CHANNELS*DATA_W-1:0] s2_data;
  logic [SUM_W-1:0]           sum_c;
  logic [SUM_W-1:0]           out_sum_q;

  always_comb begin
    sum_c = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_c = sum_c + SUM_W'(s2_data[c*DATA_W +: DATA_W]);
    end
  end

  // Data rides alongside the adder so out_data and out_sum leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_data     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
    end else begin
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      if (s1_valid) s2_data <= s1_data;
      if (s2_valid) begin
        out_data_q <= s2_data;
        out_sum_q  <= sum_c;
      end
    end
  end

  assign bus.out_sum = out_sum_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= s1_valid;
      if (s1_valid) out_data_q <= s1_data;
    end
  end

  assign bus.out_sum = '0;
`endif

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Self-checking bench for xpb_lut_bank: directed tables plus randomized traffic
// against an array/queue model of table contents and lookup results.
module tb_xpb_lut_bank;
  import xpb_pkg::*;

  localparam int DEPTH = 1 << SEL_W;
  localparam int LSW   = CHANNELS * SEL_W;

  typedef struct {
    logic [CHANNELS*DATA_W-1:0] data;
    int                         due;
  } exp_t;

  typedef struct {
    logic [LSW-1:0]         sel;
    logic [CHANNELS*12-1:0] exp;
    logic [15:0]            sum;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  residue_t mem_m [CHANNELS][DEPTH];
  bit       ld_m  [CHANNELS][DEPTH];
  int       n_loaded = 0;
  bit       loaded_m = 1'b0;
  bit       err_m = 1'b0;
  exp_t     q[$];
  vec_t     vecs[6];

  xpb_lut_if bus ();

  xpb_lut_bank dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [SUM_W-1:0] got, input logic [SUM_W-1:0] want);
    logic [63:0] g, w;
    n_vec++;
    if (got !== want) begin
      n_miss++;
      g = got[63:0];
      w = want[63:0];
      $display("FAIL %s: got %h want %h (low 64 bits) at cycle %0d", nm, g, w, cyc);
    end
  endtask

  task automatic rand_res(output residue_t r);
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++)
      for (int a = 0; a < DEPTH; a++) ld_m[c][a] = 1'b0;
    n_loaded = 0;
    loaded_m = 1'b0;
    err_m    = 1'b0;
    q.delete();
  endtask

  // Advance one clock: predict handshakes from the model, record expected results.
  task automatic tick();
    bit   lk_acc, wr_acc, wr_rdy_m;
    exp_t e;
    #1;
    lk_acc   = bus.lk_valid && loaded_m;
    wr_rdy_m = !lk_acc && !bus.tbl_clear;
    wr_acc   = bus.wr_valid && wr_rdy_m;
    chk("wr_ready", SUM_W'(bus.wr_ready), SUM_W'(wr_rdy_m));
    chk("lk_ready", SUM_W'(bus.lk_ready), SUM_W'(loaded_m));
    if (lk_acc) begin
      for (int c = 0; c < CHANNELS; c++)
        e.data[c*DATA_W +: DATA_W] = mem_m[c][bus.lk_sel[c*SEL_W +: SEL_W]];
      e.due = cyc + LATENCY;
      q.push_back(e);
    end
    if (wr_acc && int'(bus.wr_chan) < CHANNELS && bus.wr_addr != '0) begin
      mem_m[bus.wr_chan][bus.wr_addr] = bus.wr_data;
      if (!ld_m[bus.wr_chan][bus.wr_addr]) begin
        ld_m[bus.wr_chan][bus.wr_addr] = 1'b1;
        n_loaded++;
      end
    end
    err_m = bus.lk_valid && !loaded_m;
    if (bus.tbl_clear) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int a = 0; a < DEPTH; a++) ld_m[c][a] = 1'b0;
      n_loaded = 0;
    end
    loaded_m = (n_loaded == CHANNELS * (DEPTH - 1));
    @(posedge clk);
    #1;
    chk("tbl_loaded", SUM_W'(bus.tbl_loaded), SUM_W'(loaded_m));
    chk("lk_err", SUM_W'(bus.lk_err), SUM_W'(err_m));
  endtask

  task automatic load_all();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int a = 1; a < DEPTH; a++) begin
        bus.wr_valid = 1'b1;
        bus.wr_chan  = CH_W'(c);
        bus.wr_addr  = SEL_W'(a);
        bus.wr_data  = DATA_W'((c << 8) | a);
        tick();
      end
    end
    bus.wr_valid = 1'b0;
  endtask

  exp_t             me;
  logic [SUM_W-1:0] msum;
  bit               mdue;
  residue_t         mg, mw;
  int               mbad;

  always @(negedge clk) begin
    if (rst_n) begin
      mdue = (q.size() > 0) && (q[0].due == cyc);
      if (mdue || bus.out_valid) begin
        n_vec++;
        if (!mdue) begin
          n_miss++;
          $display("FAIL out_valid_unexpected: got 1 want 0 at cycle %0d", cyc);
        end else begin
          me = q.pop_front();
          msum = '0;
`ifdef XPB_LUT_SUM_EN
          for (int c = 0; c < CHANNELS; c++) msum = msum + SUM_W'(me.data[c*DATA_W +: DATA_W]);
`endif
          mbad = -1;
          for (int c = 0; c < CHANNELS; c++)
            if (bus.out_data[c*DATA_W +: DATA_W] !== me.data[c*DATA_W +: DATA_W]) mbad = c;
          if (!bus.out_valid || mbad >= 0 || bus.out_sum !== msum) begin
            n_miss++;
            if (mbad < 0) mbad = 0;
            mg = bus.out_data[mbad*DATA_W +: DATA_W];
            mw = me.data[mbad*DATA_W +: DATA_W];
            $display("FAIL result: valid %b ch%0d got %h want %h sum_ok %b at cycle %0d",
                     bus.out_valid, mbad, mg[63:0], mw[63:0], bus.out_sum === msum, cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    residue_t d;
    vecs[0] = '{sel: {5'd31, 5'd0, 5'd1, 5'd17},  exp: {12'h31F, 12'h000, 12'h101, 12'h011}, sum: 16'h0431};
    vecs[1] = '{sel: {5'd0, 5'd0, 5'd0, 5'd0},    exp: {12'h000, 12'h000, 12'h000, 12'h000}, sum: 16'h0000};
    vecs[2] = '{sel: {5'd1, 5'd1, 5'd1, 5'd1},    exp: {12'h301, 12'h201, 12'h101, 12'h001}, sum: 16'h0604};
    vecs[3] = '{sel: {5'd31, 5'd31, 5'd31, 5'd31}, exp: {12'h31F, 12'h21F, 12'h11F, 12'h01F}, sum: 16'h067C};
    vecs[4] = '{sel: {5'd16, 5'd8, 5'd2, 5'd0},   exp: {12'h310, 12'h208, 12'h102, 12'h000}, sum: 16'h061A};
    vecs[5] = '{sel: {5'd0, 5'd30, 5'd0, 5'd15},  exp: {12'h000, 12'h21E, 12'h000, 12'h00F}, sum: 16'h022D};

    for (int c = 0; c < CHANNELS; c++)
      for (int a = 0; a < DEPTH; a++) mem_m[c][a] = '0;
    model_reset();
    bus.tbl_clear = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_chan   = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.lk_valid  = 1'b0;
    bus.lk_sel    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", SUM_W'(bus.out_valid), '0);
    chk("rst_out_data", SUM_W'(bus.out_data[DATA_W-1:0]), '0);
    chk("rst_out_sum", bus.out_sum, '0);
    chk("rst_lk_err", SUM_W'(bus.lk_err), '0);
    chk("rst_tbl_loaded", SUM_W'(bus.tbl_loaded), '0);
    rst_n = 1'b1;
    tick();

    // Lookup before the table is loaded
    bus.lk_valid = 1'b1;
    bus.lk_sel   = LSW'($urandom);
    tick();
    bus.lk_valid = 1'b0;
    repeat (LATENCY + 1) tick();
    chk("early_out_valid", SUM_W'(bus.out_valid), '0);

    // Writes to entry 0 are discarded
    for (int c = 0; c < CHANNELS; c++) begin
      bus.wr_valid = 1'b1;
      bus.wr_chan  = CH_W'(c);
      bus.wr_addr  = '0;
      bus.wr_data  = DATA_W'(32'hDEAD);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();

    // Full load; tbl_loaded tracked every cycle by tick()
    load_all();
    chk("loaded_after_last", SUM_W'(bus.tbl_loaded), SUM_W'(1'b1));
    chk("lk_ready_after_last", SUM_W'(bus.lk_ready), SUM_W'(1'b1));

    // Table-driven lookups with constant expectations
    for (int i = 0; i < 6; i++) begin
      bus.lk_valid = 1'b1;
      bus.lk_sel   = vecs[i].sel;
      tick();
      bus.lk_valid = 1'b0;
      repeat (LATENCY - 1) tick();
      chk($sformatf("vec%0d_valid", i), SUM_W'(bus.out_valid), SUM_W'(1'b1));
      for (int c = 0; c < CHANNELS; c++)
        chk($sformatf("vec%0d_ch%0d", i, c), SUM_W'(bus.out_data[c*DATA_W +: DATA_W]),
            SUM_W'(vecs[i].exp[c*12 +: 12]));
`ifdef XPB_LUT_SUM_EN
      chk($sformatf("vec%0d_sum", i), bus.out_sum, SUM_W'(vecs[i].sum));
`else
      chk($sformatf("vec%0d_sum", i), bus.out_sum, '0);
`endif
      tick();
      chk($sformatf("vec%0d_hold", i), SUM_W'(bus.out_data[3*DATA_W +: DATA_W]),
          SUM_W'(vecs[i].exp[3*12 +: 12]));
    end

    // Lookup and write in the same cycle: lookup wins, write follows
    bus.lk_valid = 1'b1;
    bus.lk_sel   = {CHANNELS{5'd5}};
    bus.wr_valid = 1'b1;
    bus.wr_chan  = CH_W'(2);
    bus.wr_addr  = SEL_W'(5);
    bus.wr_data  = DATA_W'(32'hABCDE);
    tick();
    bus.lk_valid = 1'b0;
    tick();
    bus.wr_valid = 1'b0;
    bus.lk_valid = 1'b1;
    tick();
    bus.lk_valid = 1'b0;
    repeat (LATENCY - 1) tick();
    chk("collide_new_value", SUM_W'(bus.out_data[2*DATA_W +: DATA_W]), SUM_W'(32'hABCDE));
    tick();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bus.lk_valid = ($urandom_range(0, 1) == 1);
      bus.lk_sel   = LSW'($urandom);
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_chan  = CH_W'($urandom);
      bus.wr_addr  = SEL_W'($urandom);
      rand_res(d);
      bus.wr_data  = d;
      tick();
    end
    bus.lk_valid = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (LATENCY + 1) tick();

    // Back-to-back lookups with a clear while results are in flight
    for (int i = 0; i < 8; i++) begin
      bus.lk_valid = 1'b1;
      bus.lk_sel   = LSW'($urandom);
      tick();
    end
    bus.lk_valid  = 1'b0;
    bus.tbl_clear = 1'b1;
    tick();
    bus.tbl_clear = 1'b0;
    chk("clear_loaded", SUM_W'(bus.tbl_loaded), '0);
    repeat (LATENCY + 2) tick();
    chk("clear_drained", SUM_W'(q.size()), '0);

    // Reload, then reset with results in flight
    load_all();
    for (int i = 0; i < LATENCY; i++) begin
      bus.lk_valid = 1'b1;
      bus.lk_sel   = LSW'($urandom);
      tick();
    end
    bus.lk_valid = 1'b0;
    #1;
    chk("pre_rst_valid", SUM_W'(bus.out_valid), SUM_W'(1'b1));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", SUM_W'(bus.out_valid), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LATENCY + 3) tick();
    chk("post_rst_loaded", SUM_W'(bus.tbl_loaded), '0);
    chk("post_rst_queue", SUM_W'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
